// File: rtl/debounce_scan_ctrl_pkg.sv
// Shared types and helpers for the round-robin debounce controller.
// The optional edge-pulse outputs are enabled by defining DEB_EVENT_EN.
package debounce_scan_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int DEF_N_CH       = 4;
    localparam int DEF_TICK_DIV   = 1000;
    localparam int DEF_STABLE_CNT = 8;
    localparam bit DEF_RESET_VAL  = 1'b0;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_scan_ctrl_sync2.sv
// Two-flop synchronizer for one raw input bit.
// Reset level is a parameter so it matches the debounced output reset level.
module deb_sync2 #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/debounce_scan_ctrl.sv
// Debounce controller: one shared sample/compare engine visits N_CH channels round-robin.
// Define DEB_EVENT_EN to build the rise_pulse/fall_pulse logic; otherwise both are tied low.
module debounce_scan_ctrl
    import debounce_scan_ctrl_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int TICK_DIV   = DEF_TICK_DIV,
    parameter int STABLE_CNT = DEF_STABLE_CNT,
    parameter bit RESET_VAL  = DEF_RESET_VAL
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sig_in,
    output logic [N_CH-1:0] sig_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            overrun
);

    localparam int IDX_W   = width_for(N_CH);
    localparam int CNT_W   = width_for(STABLE_CNT + 1);
    localparam int PRESC_W = width_for(TICK_DIV);

    logic [N_CH-1:0] sync;

    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        deb_sync2 #(.RESET_VAL(RESET_VAL)) u_sync (
            .clk (clk),
            .rst (rst),
            .d   (sig_in[g]),
            .q   (sync[g])
        );
    end

    logic [PRESC_W-1:0] presc;
    logic               tick;

    assign tick = (presc == PRESC_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                if (idx == IDX_W'(N_CH - 1)) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    // Shared engine: only the channel selected by idx is looked at this cycle.
    logic [N_CH-1:0][CNT_W-1:0] cnt;
    logic                       cur_sample;
    logic                       cur_out;
    logic [CNT_W-1:0]           cur_cnt;
    logic                       differ;
    logic                       flip;

    always_comb begin
        cur_sample = sync[idx];
        cur_out    = sig_out[idx];
        cur_cnt    = cnt[idx];
        differ     = (state == SCAN) && (cur_sample != cur_out);
        flip       = differ && (cur_cnt == CNT_W'(STABLE_CNT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_out <= {N_CH{RESET_VAL}};
            cnt     <= '0;
        end else if (state == SCAN) begin
            if (!differ) begin
                cnt[idx] <= '0;
            end else if (flip) begin
                cnt[idx]     <= '0;
                sig_out[idx] <= ~cur_out;
            end else begin
                cnt[idx] <= cur_cnt + 1'b1;
            end
        end
    end

    // A tick landing mid-scan is simply ignored by the FSM; remember that it happened.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (tick && (state == SCAN)) begin
            overrun <= 1'b1;
        end
    end

`ifdef DEB_EVENT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            rise_pulse <= '0;
            fall_pulse <= '0;
            if (flip) begin
                if (cur_out == 1'b0) begin
                    rise_pulse[idx] <= 1'b1;
                end else begin
                    fall_pulse[idx] <= 1'b1;
                end
            end
        end
    end
`else
    assign rise_pulse = '0;
    assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Self-checking bench for debounce_scan_ctrl (N_CH=4, TICK_DIV=8, STABLE_CNT=3),
// plus a second instance with TICK_DIV=4 that must raise overrun.
module tb_debounce_scan_ctrl;
    import debounce_scan_ctrl_pkg::*;

    localparam int N_CH   = 4;
    localparam int TDIV   = 8;
    localparam int STABLE = 3;

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] sig_in;
    logic [N_CH-1:0] sig_out, rise_pulse, fall_pulse;
    logic            overrun;
    logic [N_CH-1:0] sig_out_o, rise_pulse_o, fall_pulse_o;
    logic            overrun_o;

    debounce_scan_ctrl #(
        .N_CH(N_CH), .TICK_DIV(TDIV), .STABLE_CNT(STABLE), .RESET_VAL(1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .sig_out    (sig_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .overrun    (overrun)
    );

    debounce_scan_ctrl #(
        .N_CH(N_CH), .TICK_DIV(4), .STABLE_CNT(STABLE), .RESET_VAL(1'b0)
    ) dut_o (
        .clk        (clk),
        .rst        (rst),
        .sig_in     (sig_in),
        .sig_out    (sig_out_o),
        .rise_pulse (rise_pulse_o),
        .fall_pulse (fall_pulse_o),
        .overrun    (overrun_o)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ecount = number of rising edges since rst was released
    int ecount;
    always @(posedge clk or posedge rst) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ecount);
    endtask

    // ---------------- scoreboard ----------------
    // entry = {edge at which sig_out changes [20:5], channel [4:1], new level [0]}
    logic [20:0] exp_q[$];

    task automatic push_exp(input int e_at, input int ch, input logic lvl);
        logic [20:0] v;
        int i;
        v = {e_at[15:0], ch[3:0], lvl};
        i = 0;
        while (i < exp_q.size() && exp_q[i] < v) i++;
        exp_q.insert(i, v);
    endtask

    // Edge after which channel k shows a new level, for a clean input change
    // driven at the negedge following edge c: two sync flops, then STABLE samples
    // one tick apart; channel k is sampled in the cycle after edges p = k (mod TDIV), p >= TDIV.
    function automatic int exp_edge(input int c, input int k);
        int p;
        p = c + 2;
        if (p < TDIV) p = TDIV;
        while ((p % TDIV) != k) p++;
        return p + (STABLE - 1) * TDIV + 1;
    endfunction

    logic [N_CH-1:0] prev_out;
    logic [N_CH-1:0] changed, exp_rise, exp_fall;
    assign changed = sig_out ^ prev_out;
`ifdef DEB_EVENT_EN
    assign exp_rise = changed & sig_out;
    assign exp_fall = changed & ~sig_out;
`else
    assign exp_rise = '0;
    assign exp_fall = '0;
`endif

    always @(negedge clk) begin
        if (rst) begin
            prev_out <= sig_out;
        end else begin
            if (changed != '0) begin
                chk("one_change_per_cycle", 32'($countones(changed)), 32'd1);
                for (int k = 0; k < N_CH; k++) begin
                    if (changed[k]) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_change", 32'(k), 32'hFF);
                        end else begin
                            chk("event", 32'({ecount[15:0], 4'(k), sig_out[k]}), 32'(exp_q.pop_front()));
                        end
                    end
                end
            end
            if (changed != '0 || rise_pulse != '0 || fall_pulse != '0) begin
                chk("rise_pulse", 32'(rise_pulse), 32'(exp_rise));
                chk("fall_pulse", 32'(fall_pulse), 32'(exp_fall));
            end
            prev_out <= sig_out;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_edge(input int target);
        int guard;
        guard = 0;
        while (ecount < target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (ecount != target) chk("wait_edge", 32'(ecount), 32'(target));
    endtask

    task automatic drain(input int budget);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic drive_bit(input int ch, input logic lvl);
        sig_in[ch] = lvl;
        push_exp(exp_edge(ecount, ch), ch, lvl);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int e_rst;
        rst    = 1'b1;
        sig_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_sig_out", 32'(sig_out), 32'h0);
        chk("rst_pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        release_reset();

        // First tick after reset, and the misconfigured instance overrunning.
        wait_edge(TDIV - 1);
        chk("state_before_tick", 32'(dut.state), 32'(IDLE));
        chk("overrun_o_early", 32'(overrun_o), 32'h0);
        wait_edge(TDIV);
        chk("state_first_scan", 32'(dut.state), 32'(SCAN));
        chk("overrun_o_set", 32'(overrun_o), 32'h1);

        // Clean press on channel 2 at a random phase.
        repeat ($urandom_range(0, 7)) @(negedge clk);
        drive_bit(2, 1'b1);
        drain(200);
        chk("press_sig_out", 32'(sig_out), 32'h4);

        // Bounce on channel 1: high bursts shorter than two ticks, low gaps
        // long enough to always contain a sample.
        for (int b = 0; b < 5; b++) begin
            sig_in[1] = 1'b1;
            repeat ($urandom_range(1, 15)) @(negedge clk);
            sig_in[1] = 1'b0;
            repeat ($urandom_range(8, 12)) @(negedge clk);
        end
        chk("bounce_held_low", 32'(sig_out[1]), 32'h0);
        drive_bit(1, 1'b1);
        drain(200);
        chk("bounce_sig_out", 32'(sig_out), 32'h6);

        // Settle all high, then release all at once aligned so they land in one scan.
        drive_bit(0, 1'b1);
        drive_bit(3, 1'b1);
        drain(200);
        chk("all_high", 32'(sig_out), 32'hF);
        while ((ecount % TDIV) != 5) @(negedge clk);
        for (int k = 0; k < N_CH; k++) drive_bit(k, 1'b0);
        drain(200);
        chk("all_low", 32'(sig_out), 32'h0);
        chk("overrun_o_sticky", 32'(overrun_o), 32'h1);

        // Reset in the very cycle channel 2 would fall: no pulse, immediate reset values.
        drive_bit(2, 1'b1);
        drain(200);
        chk("repress_sig_out", 32'(sig_out), 32'h4);
        sig_in[2] = 1'b0;
        e_rst = exp_edge(ecount, 2);
        wait_edge(e_rst - 1);
        chk("pre_reset_state", 32'(dut.state), 32'(SCAN));
        #1 rst = 1'b1;
        #1;
        chk("midscan_sig_out", 32'(sig_out), 32'h0);
        chk("midscan_pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
        chk("midscan_state", 32'(dut.state), 32'(IDLE));
        chk("midscan_overrun_o", 32'(overrun_o), 32'h0);
        repeat (2) @(negedge clk);
        release_reset();
        wait_edge(TDIV - 1);
        chk("post_rst_idle", 32'(dut.state), 32'(IDLE));
        wait_edge(TDIV);
        chk("post_rst_scan", 32'(dut.state), 32'(SCAN));
        wait_edge(5 * TDIV);
        chk("post_rst_sig_out", 32'(sig_out), 32'h0);
        chk("overrun_main", 32'(overrun), 32'h0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debounce_scan_ctrl.md
Name: debounce_scan_ctrl

Overview:
Debounce controller for N_CH raw inputs such as pushbuttons, lock-detect and PLL select switches. A single shared sample-and-compare engine serves all channels; a prescaler-driven FSM visits the channels round-robin, one per clock. The block sits between the board-level inputs and the PLL control logic. It replaces one free-running debouncer per input.

Parameters:
N_CH, 4, number of input channels (1..16)
TICK_DIV, 1000, clk cycles per sample tick; must be >= N_CH+2
STABLE_CNT, 8, consecutive differing samples needed to flip an output (2..255)
RESET_VAL, 0, reset level of every sig_out bit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sig_in  in  N_CH  raw asynchronous inputs
sig_out  out  N_CH  debounced levels
rise_pulse  out  N_CH  one-cycle pulse when sig_out bit goes 0->1
fall_pulse  out  N_CH  one-cycle pulse when sig_out bit goes 1->0
overrun  out  1  sticky: a tick arrived while a scan was still in progress

Behaviour:
- Reset, asynchronous on rst high:
  - sig_out = {N_CH{RESET_VAL}}, pulses = 0, overrun = 0.
  - All channel counters = 0, prescaler = 0, synchronizers = RESET_VAL, FSM = IDLE.
- Synchronizer: each sig_in bit passes through a 2-flop synchronizer. The engine only sees synchronized values.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = 1 for one cycle when count == TICK_DIV-1.
- FSM states IDLE and SCAN; idx is a channel index of width clog2(N_CH), min 1.
  - IDLE: on tick, go to SCAN with idx = 0.
  - SCAN: channel idx is processed this cycle. If idx == N_CH-1, go to IDLE; otherwise idx++.
- Per-channel update, using the synchronized sample s and counter cnt[idx] of width clog2(STABLE_CNT+1):
  - s == sig_out[idx]: cnt cleared.
  - s != sig_out[idx] and cnt+1 < STABLE_CNT: cnt increments.
  - s != sig_out[idx] and cnt+1 == STABLE_CNT: sig_out[idx] toggles, cnt cleared, and the matching rise/fall pulse bit is high for exactly the next cycle.
- Latency: tick at cycle T, so channel k is processed at T+1+k. Its sig_out is visible at T+2+k.
- Worst case from a clean input edge to sig_out: 2 sync cycles + STABLE_CNT ticks + N_CH cycles.
- Glitch rejection: a sample equal to the current output resets that channel's count. Any glitch shorter than STABLE_CNT ticks never propagates.
- Simultaneous events: at most one channel is updated per cycle, so pulses on different channels never coincide within one scan.
- Overrun: a tick arriving during SCAN is dropped and overrun is set. overrun clears only on rst. With the TICK_DIV rule met this cannot occur; it is a guard against misconfiguration.
- Reset mid-scan: all state returns to reset values immediately. No pulse is emitted for a channel whose scan was interrupted.
- Counters never saturate beyond STABLE_CNT-1.

Optional Feature:
DEB_EVENT_EN
- Defined: rise_pulse and fall_pulse are generated as described above.
- Undefined: the pulse logic is not compiled. Both ports are tied to 0; sig_out and overrun behaviour is unchanged.

Decomposition:
- Shared package: state enum (IDLE, SCAN); a clog2-based width helper for idx and cnt; default parameter constants.
- One sub-module: deb_sync2, the 2-flop synchronizer, instantiated per channel with reset value RESET_VAL.
- FSM, prescaler and shared engine remain in the top module.

Test Plan:
All scenarios use N_CH=4, TICK_DIV=8, STABLE_CNT=3 unless stated.
1. Reset: assert rst mid-SCAN at cycle 13 -> sig_out=0, pulses=0, overrun=0 and FSM IDLE in the same cycle; first tick then lands 8 cycles after rst deasserts.
2. Clean press: sig_in[2] 0->1 held -> sig_out[2]=1 on the 3rd tick after sync (processed at T+3, visible T+4); rise_pulse[2] high exactly 1 cycle; no other bit changes.
3. Bounce: sig_in[1] toggles every 5 cycles for 60 cycles, then holds 1 -> sig_out[1] stays 0 throughout the bounce, then goes 1 after 3 stable ticks; exactly one rise_pulse.
4. Release: all inputs 1->0 simultaneously after settling at 1 -> fall_pulse on ch0..ch3 in consecutive cycles T+2..T+5, never two in the same cycle.
5. Overrun: rebuild with TICK_DIV=4, N_CH=4 -> overrun=1 after the first scan and remains 1 until rst.
6. DEB_EVENT_EN undefined: rerun scenario 2 -> sig_out[2] timing identical, rise_pulse/fall_pulse constant 0.
